onehot_decode_seq: RTL

- Sequential inverse of the team's one-hot priority-position encoder: converts a position code back into a WIDTH-bit one-hot word.
- Code convention: code k in 1..WIDTH sets bit k-1; code WIDTH+1 means the all-zero word; any other code is illegal.
- Uses an iterative shift, one bit per cycle, so no wide decoder mux is needed.
- Sits between the control unit (code producer) and datapath consumers (register-select, shift-mask), with valid/ready handshakes on both sides.

---
 rtl/onehot_decode_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/onehot_decode_seq.sv
// onehot_decode_seq
//   Sequential position-code to one-hot decoder. A code k in 1..WIDTH
//   produces a word with only bit k-1 set, code WIDTH+1 produces the
//   all-zero word, and any other code is flagged as an error. The one-hot
//   word is built by shifting a single bit one position per cycle, which
//   avoids a wide decoder mux.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = reset asserted)
//   in_code    position code to decode (sampled only on the accept edge)
//   in_valid   producer offers in_code
//   in_ready   block can accept a code (IDLE and not in reset)
//   out_data   decoded one-hot or zero word
//   out_err    code was illegal; qualified by out_valid
//   out_valid  out_data/out_err are valid
//   out_ready  consumer accepts the result
//   busy       block is shifting or holding a result
module onehot_decode_seq #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CODE_W-1:0] MAX_CODE  = CODE_W'(WIDTH);
    localparam logic [CODE_W-1:0] ZERO_CODE = CODE_W'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic               accept;

    // in_ready is gated by rst so it reads 0 for the whole reset period.
    assign in_ready  = rst & (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid & in_ready;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((in_code != '0) && (in_code <= MAX_CODE)) begin
                        // cnt counts the remaining shifts; code k needs k-1.
                        shreg_d = WIDTH'(1);
                        cnt_d   = CNT_W'(in_code - 1'b1);
                        state_d = SHIFT;
                    end else begin
                        data_d  = '0;
                        err_d   = (in_code != ZERO_CODE);
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    data_d  = shreg_q;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                // out_data/out_err keep their last values after the handshake.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
